halfword_reg_loader: RTL and testbench

Write-side companion to the register-bank datapath: accepts a 32-bit operand from a 16-bit input bus as two strobed halves (low first, then high), assembles it, and issues a single-cycle write into the register bank at a selected destination. Mirrors the read side, which presents results as low half then high half on a 16-bit output. Sits between board switches/buttons and the register bank's write port, and shares that port with the ALU write-back path.

---
 rtl/halfword_reg_loader_pkg.sv | 17 +
 rtl/halfword_reg_loader_if.sv | 25 ++
 rtl/halfword_reg_loader_strobe_sync.sv | 17 +
 rtl/halfword_reg_loader.sv | 81 ++++++++
 tb/tb_halfword_reg_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/halfword_reg_loader_pkg.sv
// Shared widths and FSM encoding for the register-bank write-side loader.
package halfword_reg_loader_pkg;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_HELD = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } wr_req_t;
endpackage

// File: rtl/halfword_reg_loader_if.sv
// Halfword input bus and register-bank write port of the loader.
interface halfword_reg_loader_if;
  import halfword_reg_loader_pkg::*;

  logic [HALF_W-1:0] in;
  logic [ADDR_W-1:0] destination;
  logic              strobe;
  logic              abort;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              write;
  logic              busy;
  logic              loaded;
  logic [HALF_W-1:0] echo;

  modport master (
    output in, destination, strobe, abort,
    input  wr_data, wr_addr, write, busy, loaded, echo
  );

  modport slave (
    input  in, destination, strobe, abort,
    output wr_data, wr_addr, write, busy, loaded, echo
  );
endinterface

// File: rtl/halfword_reg_loader_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous strobe.
module strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic cap
);
  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1:0], strobe};
  end

  assign cap = vld_pipe[1] & ~vld_pipe[2];
endmodule

// File: rtl/halfword_reg_loader.sv
// Assembles a 32-bit word from two strobed halfwords and issues one bank write.
// Optional feature macro: STROBE_SYNC_EN (synchronize + edge-detect strobe).
module halfword_reg_loader
  import halfword_reg_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  halfword_reg_loader_if.slave   bus
);
  logic cap;

`ifdef STROBE_SYNC_EN
  strobe_sync u_strobe_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (bus.strobe),
    .cap    (cap)
  );
`else
  assign cap = bus.strobe;
`endif

  state_e            state;
  logic [HALF_W-1:0] lo_q;
  logic [ADDR_W-1:0] dest_q;
  wr_req_t           wr_q;
  logic              write_q, busy_q, loaded_q;
  logic [HALF_W-1:0] echo_q;

  // The high half lands straight in the write register, so it holds after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lo_q     <= '0;
      dest_q   <= '0;
      wr_q     <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      echo_q   <= '0;
    end else begin
      write_q <= 1'b0;
      case (state)
        IDLE: if (cap) begin
          lo_q     <= bus.in;
          dest_q   <= bus.destination;
          echo_q   <= bus.in;
          loaded_q <= 1'b0;
          busy_q   <= 1'b1;
          state    <= LO_HELD;
        end
        LO_HELD: if (bus.abort) begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end else if (cap) begin
          echo_q       <= bus.in;
          wr_q.data    <= {bus.in, lo_q};
          wr_q.addr    <= dest_q;
          write_q      <= 1'b1;
          busy_q       <= 1'b0;
          state        <= COMMIT;
        end
        COMMIT: begin
          loaded_q <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_data = wr_q.data;
  assign bus.wr_addr = wr_q.addr;
  assign bus.write   = write_q;
  assign bus.busy    = busy_q;
  assign bus.loaded  = loaded_q;
  assign bus.echo    = echo_q;
endmodule

// File: tb/tb_halfword_reg_loader.sv
// Self-checking bench for halfword_reg_loader; writes are checked against a word-level scoreboard.
module tb_halfword_reg_loader;
  import halfword_reg_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  halfword_reg_loader_if bus();

  halfword_reg_loader dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] got_data[$];
  logic [3:0]  got_addr[$];
  int          got_cyc[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write pulse, one entry per high cycle
  always @(negedge clk) if (bus.write === 1'b1) begin
    got_data.push_back(bus.wr_data);
    got_addr.push_back(bus.wr_addr);
    got_cyc.push_back(cyc);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Present a halfword so that it is captured on the final edge of this task;
  // ab/rs are applied on that same edge.
  task automatic cap_edge(input logic [15:0] d, input logic [3:0] a, input logic ab, input logic rs);
    bus.in = d; bus.destination = a; bus.strobe = 1'b1;
`ifdef STROBE_SYNC_EN
    tick; bus.strobe = 1'b0; tick;
`endif
    bus.abort = ab; reset = rs;
    tick;
    bus.strobe = 1'b0; bus.abort = 1'b0; reset = 1'b0;
  endtask

  task automatic do_cap(input logic [15:0] d, input logic [3:0] a);
    cap_edge(d, a, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.in = 16'hFFFF; bus.destination = 4'hF; bus.strobe = 1'b1; bus.abort = 1'b0;
    tick; tick; tick;
    reset = 1'b0; bus.strobe = 1'b0;
    checks++; if (bus.write   !== 1'b0)  begin errors++; $display("FAIL reset_write act=%h exp=0", bus.write); end
    checks++; if (bus.busy    !== 1'b0)  begin errors++; $display("FAIL reset_busy act=%h exp=0", bus.busy); end
    checks++; if (bus.loaded  !== 1'b0)  begin errors++; $display("FAIL reset_loaded act=%h exp=0", bus.loaded); end
    checks++; if (bus.echo    !== 16'h0) begin errors++; $display("FAIL reset_echo act=%h exp=0", bus.echo); end
    checks++; if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data act=%h exp=0", bus.wr_data); end
    checks++; if (bus.wr_addr !== 4'h0)  begin errors++; $display("FAIL reset_wr_addr act=%h exp=0", bus.wr_addr); end
  endtask

  task automatic test_basic_load;
    do_cap(16'h5678, 4'd3);
    checks++; if (bus.busy !== 1'b1)     begin errors++; $display("FAIL basic_busy act=%h exp=1", bus.busy); end
    checks++; if (bus.echo !== 16'h5678) begin errors++; $display("FAIL basic_echo_lo act=%h exp=5678", bus.echo); end
    checks++; if (bus.write !== 1'b0)    begin errors++; $display("FAIL basic_early_write act=%h exp=0", bus.write); end
    do_cap(16'h1234, 4'hF);
    checks++; if (bus.write !== 1'b1)          begin errors++; $display("FAIL basic_write act=%h exp=1", bus.write); end
    checks++; if (bus.wr_data !== 32'h12345678) begin errors++; $display("FAIL basic_wr_data act=%h exp=12345678", bus.wr_data); end
    checks++; if (bus.wr_addr !== 4'd3)        begin errors++; $display("FAIL basic_wr_addr act=%h exp=3", bus.wr_addr); end
    checks++; if (bus.echo !== 16'h1234)       begin errors++; $display("FAIL basic_echo_hi act=%h exp=1234", bus.echo); end
    checks++; if (bus.loaded !== 1'b0)         begin errors++; $display("FAIL basic_loaded_early act=%h exp=0", bus.loaded); end
    tick;
    checks++; if (bus.write !== 1'b0)           begin errors++; $display("FAIL basic_pulse_len act=%h exp=0", bus.write); end
    checks++; if (bus.loaded !== 1'b1)          begin errors++; $display("FAIL basic_loaded act=%h exp=1", bus.loaded); end
    checks++; if (bus.busy !== 1'b0)            begin errors++; $display("FAIL basic_busy_after act=%h exp=0", bus.busy); end
    checks++; if (bus.wr_data !== 32'h12345678) begin errors++; $display("FAIL basic_hold act=%h exp=12345678", bus.wr_data); end
  endtask

  task automatic test_abort;
    int n0 = got_data.size();
    do_cap(16'hAAAA, 4'd7);
    bus.abort = 1'b1; tick; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy act=%h exp=0", bus.busy); end
    do_cap(16'h0001, 4'd5);
    do_cap(16'h0002, 4'd5);
    checks++; if (bus.wr_data !== 32'h00020001) begin errors++; $display("FAIL abort_wr_data act=%h exp=00020001", bus.wr_data); end
    checks++; if (bus.wr_addr !== 4'd5)         begin errors++; $display("FAIL abort_wr_addr act=%h exp=5", bus.wr_addr); end
    tick;
    checks++; if (got_data.size() - n0 !== 1) begin errors++; $display("FAIL abort_write_count act=%0d exp=1", got_data.size() - n0); end
    for (int i = n0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i][15:0] === 16'hAAAA || got_data[i][31:16] === 16'hAAAA) begin
        errors++; $display("FAIL abort_stale act=%h exp=no AAAA half", got_data[i]);
      end
    end
  endtask

  task automatic test_collision;
    int n0 = got_data.size();
    do_cap(16'h0BEE, 4'd9);
    cap_edge(16'hC0DE, 4'd9, 1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL coll_busy act=%h exp=0", bus.busy); end
    checks++; if (bus.write !== 1'b0)    begin errors++; $display("FAIL coll_write act=%h exp=0", bus.write); end
    checks++; if (bus.echo !== 16'h0BEE) begin errors++; $display("FAIL coll_echo act=%h exp=0bee", bus.echo); end
    checks++; if (bus.loaded !== 1'b0)   begin errors++; $display("FAIL coll_loaded act=%h exp=0", bus.loaded); end
    tick; tick;
    checks++; if (got_data.size() !== n0) begin errors++; $display("FAIL coll_write_count act=%0d exp=%0d", got_data.size(), n0); end
  endtask

  task automatic test_reset_mid;
    int n0;
    do_cap(16'h1111, 4'd4);
    reset = 1'b1; tick; reset = 1'b0;
    checks++; if ({bus.write, bus.busy, bus.loaded} !== 3'b000) begin errors++; $display("FAIL rmid_lo_flags act=%b exp=000", {bus.write, bus.busy, bus.loaded}); end
    checks++; if (bus.echo !== 16'h0) begin errors++; $display("FAIL rmid_lo_echo act=%h exp=0", bus.echo); end
    n0 = got_data.size();
    do_cap(16'h2222, 4'd6);
    cap_edge(16'h3333, 4'd6, 1'b0, 1'b1);
    checks++; if ({bus.write, bus.busy, bus.loaded} !== 3'b000) begin errors++; $display("FAIL rmid_hi_flags act=%b exp=000", {bus.write, bus.busy, bus.loaded}); end
    checks++; if ({bus.wr_data, bus.wr_addr, bus.echo} !== 52'h0) begin errors++; $display("FAIL rmid_hi_data act=%h exp=0", {bus.wr_data, bus.wr_addr, bus.echo}); end
    tick; tick; tick;
    checks++; if (got_data.size() !== n0) begin errors++; $display("FAIL rmid_write_count act=%0d exp=%0d", got_data.size(), n0); end
    do_cap(16'h4444, 4'd8);
    do_cap(16'h5555, 4'd8);
    reset = 1'b1; tick; reset = 1'b0;
    checks++; if ({bus.write, bus.busy, bus.loaded} !== 3'b000) begin errors++; $display("FAIL rmid_commit_flags act=%b exp=000", {bus.write, bus.busy, bus.loaded}); end
    checks++; if ({bus.wr_data, bus.wr_addr, bus.echo} !== 52'h0) begin errors++; $display("FAIL rmid_commit_data act=%h exp=0", {bus.wr_data, bus.wr_addr, bus.echo}); end
  endtask

  task automatic test_back_to_back;
    int n0 = got_data.size();
    int gap;
`ifdef STROBE_SYNC_EN
    gap = 7;
`else
    gap = 3;
`endif
    do_cap(16'hA001, 4'd1); do_cap(16'hA002, 4'd1);
    tick;
    do_cap(16'hB001, 4'd0); do_cap(16'hB002, 4'd0);
    tick;
    checks++;
    if (got_data.size() - n0 !== 2) begin
      errors++; $display("FAIL b2b_count act=%0d exp=2", got_data.size() - n0);
    end else begin
      checks++; if (got_data[n0] !== 32'hA002A001)   begin errors++; $display("FAIL b2b_data0 act=%h exp=a002a001", got_data[n0]); end
      checks++; if (got_addr[n0] !== 4'd1)           begin errors++; $display("FAIL b2b_addr0 act=%h exp=1", got_addr[n0]); end
      checks++; if (got_data[n0+1] !== 32'hB002B001) begin errors++; $display("FAIL b2b_data1 act=%h exp=b002b001", got_data[n0+1]); end
      checks++; if (got_addr[n0+1] !== 4'd0)         begin errors++; $display("FAIL b2b_addr1 act=%h exp=0", got_addr[n0+1]); end
      checks++; if (got_cyc[n0+1] - got_cyc[n0] !== gap) begin errors++; $display("FAIL b2b_spacing act=%0d exp=%0d", got_cyc[n0+1] - got_cyc[n0], gap); end
    end
  endtask

  task automatic test_commit_ignore;
`ifndef STROBE_SYNC_EN
    do_cap(16'h7001, 4'd2); do_cap(16'h7002, 4'd2);
    cap_edge(16'hDEAD, 4'hE, 1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL cign_busy act=%h exp=0", bus.busy); end
    checks++; if (bus.echo !== 16'h7002) begin errors++; $display("FAIL cign_echo act=%h exp=7002", bus.echo); end
    checks++; if (bus.loaded !== 1'b1)   begin errors++; $display("FAIL cign_loaded act=%h exp=1", bus.loaded); end
`endif
  endtask

  task automatic test_strobe_held;
    int n0 = got_data.size();
    bus.in = 16'h4321; bus.destination = 4'd2; bus.strobe = 1'b1;
`ifdef STROBE_SYNC_EN
    repeat (5) tick;
    bus.strobe = 1'b0;
    repeat (3) tick;
    checks++; if (bus.busy !== 1'b1)       begin errors++; $display("FAIL held_busy act=%h exp=1", bus.busy); end
    checks++; if (got_data.size() !== n0)  begin errors++; $display("FAIL held_no_write act=%0d exp=%0d", got_data.size(), n0); end
    bus.abort = 1'b1; tick; bus.abort = 1'b0;
`else
    tick; tick;
    checks++; if (bus.write !== 1'b1)           begin errors++; $display("FAIL held_write act=%h exp=1", bus.write); end
    checks++; if (bus.wr_data !== 32'h43214321) begin errors++; $display("FAIL held_data act=%h exp=43214321", bus.wr_data); end
    tick; tick;
    checks++; if (bus.busy !== 1'b1)            begin errors++; $display("FAIL held_new_word act=%h exp=1", bus.busy); end
    tick;
    bus.strobe = 1'b0;
    tick;
    checks++; if (got_data.size() - n0 !== 2)   begin errors++; $display("FAIL held_write_count act=%0d exp=2", got_data.size() - n0); end
`endif
  endtask

  task automatic test_random;
    int n0 = got_data.size();
    exp_data.delete(); exp_addr.delete();
    for (int t = 0; t < 24; t++) begin
      logic [15:0] lo, hi;
      logic [3:0]  dst;
      int          kind;
      lo = 16'($urandom); hi = 16'($urandom); dst = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) begin
        bus.in = 16'($urandom); bus.destination = 4'($urandom); bus.abort = 1'($urandom);
        tick;
      end
      bus.abort = 1'b0;
      do_cap(lo, dst);
      checks++; if (bus.echo !== lo) begin errors++; $display("FAIL rnd_echo_lo t=%0d act=%h exp=%h", t, bus.echo, lo); end
      repeat ($urandom_range(0, 2)) begin
        bus.in = 16'($urandom); bus.destination = 4'($urandom); tick;
      end
      if (kind == 0) begin
        bus.abort = 1'b1; tick; bus.abort = 1'b0;
      end else if (kind == 1) begin
        cap_edge(hi, 4'($urandom), 1'b1, 1'b0);
        checks++; if (bus.echo !== lo) begin errors++; $display("FAIL rnd_coll_echo t=%0d act=%h exp=%h", t, bus.echo, lo); end
      end else begin
        do_cap(hi, 4'($urandom));
        exp_data.push_back({hi, lo}); exp_addr.push_back(dst);
        tick;
        checks++; if (bus.loaded !== 1'b1) begin errors++; $display("FAIL rnd_loaded t=%0d act=%h exp=1", t, bus.loaded); end
      end
    end
    tick;
    checks++;
    if (got_data.size() - n0 !== exp_data.size()) begin
      errors++; $display("FAIL rnd_count act=%0d exp=%0d", got_data.size() - n0, exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (got_data[n0+i] !== exp_data[i] || got_addr[n0+i] !== exp_addr[i]) begin
          errors++; $display("FAIL rnd_write%0d act=%h@%h exp=%h@%h", i, got_data[n0+i], got_addr[n0+i], exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  initial begin
    bus.in = '0; bus.destination = '0; bus.strobe = 1'b0; bus.abort = 1'b0;
    test_reset;
    test_basic_load;
    test_abort;
    test_collision;
    test_reset_mid;
    test_back_to_back;
    test_commit_ignore;
    test_strobe_held;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
